// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Sequencer between the EX stage and the radix-4 iterative divider.
// It accepts one DIV/DIVU request at a time and registers the operands. It
// pulses dv_div for one cycle and waits for dv_complete. It then holds the
// quotient and remainder as LO/HI on a valid/ready response port until they
// are taken. A pipeline flush kills any in-flight or pending divide. A
// watchdog cancels a divide that never completes and returns an error result.
//
// Optional build macro: DIV_ZERO_BYPASS_EN
//   When this macro is defined, a zero divisor is never sent to the divider.
//   The result LO=all-ones, HI=dividend is produced directly, and resp_valid
//   rises two cycles after accept.
//
// Parameters:
//   TAG_W    width of the opaque request tag echoed on the response
//   MAX_LAT  WAIT cycles allowed without dv_complete before the watchdog fires
//
// Ports:
//   div_clk, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_signed, req_x,
//   req_y, req_tag           request payload (1=DIV, dividend, divisor, tag)
//   flush                    kills any in-flight or pending divide
//   dv_div                   one-cycle start pulse to the divider
//   dv_signed, dv_x, dv_y    registered operands to the divider
//   dv_cancel                one-cycle cancel to the divider
//   dv_s, dv_r, dv_complete  divider quotient, remainder, done strobe
//   resp_valid/resp_ready    response handshake
//   resp_lo, resp_hi,
//   resp_tag, resp_err       quotient, remainder, tag, watchdog-error flag
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int MAX_LAT = 32
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             dv_div,
    output logic             dv_signed,
    output logic [31:0]      dv_x,
    output logic [31:0]      dv_y,
    output logic             dv_cancel,
    input  logic [31:0]      dv_s,
    input  logic [31:0]      dv_r,
    input  logic             dv_complete,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_lo,
    output logic [31:0]      resp_hi,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
);

    localparam int              WD_W    = $clog2(MAX_LAT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;

    logic             signed_q;
    logic [31:0]      x_q;
    logic [31:0]      y_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_q;
    logic             err_q;
    logic [WD_W-1:0]  wd_q;

    // Register-update strobes decoded by the FSM
    logic accept;
    logic cap_div;
    logic cap_wd;
    logic cap_zero;
    logic wd_clr;
    logic wd_inc;

    // State register
    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        dv_div     = 1'b0;
        dv_cancel  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        cap_div    = 1'b0;
        cap_wd     = 1'b0;
        cap_zero   = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;

        case (state)
            IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                wd_clr = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (y_q == 32'd0) begin
                        cap_zero  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        dv_div    = 1'b1;
                        state_nxt = WAIT;
                    end
`else
                    dv_div    = 1'b1;
                    state_nxt = WAIT;
`endif
                end
            end

            WAIT: begin
                wd_inc = 1'b1;
                // Flush wins over a same-cycle complete; the divider is told
                // to drop its work so a later complete cannot leak through.
                if (flush) begin
                    dv_cancel = 1'b1;
                    state_nxt = IDLE;
                end else if (dv_complete) begin
                    cap_div   = 1'b1;
                    state_nxt = DONE;
                end else if (wd_q == WD_LAST) begin
                    dv_cancel = 1'b1;
                    cap_wd    = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                resp_valid = !flush;
                if (flush || resp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand, tag and result registers
    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            signed_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            tag_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                signed_q <= req_signed;
                x_q      <= req_x;
                y_q      <= req_y;
                tag_q    <= req_tag;
            end
            if (cap_div) begin
                lo_q  <= dv_s;
                hi_q  <= dv_r;
                err_q <= 1'b0;
            end else if (cap_wd) begin
                lo_q  <= '0;
                hi_q  <= '0;
                err_q <= 1'b1;
            end else if (cap_zero) begin
                lo_q  <= 32'hFFFF_FFFF;
                hi_q  <= x_q;
                err_q <= 1'b0;
            end
        end
    end

    // Watchdog: cleared in ISSUE, so the first WAIT cycle sees zero
    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            wd_q <= '0;
        end else if (wd_clr) begin
            wd_q <= '0;
        end else if (wd_inc) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign dv_signed = signed_q;
    assign dv_x      = x_q;
    assign dv_y      = y_q;
    assign resp_lo   = lo_q;
    assign resp_hi   = hi_q;
    assign resp_tag  = tag_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

    localparam int TAG_W   = 4;
    localparam int MAX_LAT = 32;

    logic             div_clk = 1'b0;
    logic             resetn;
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             dv_div;
    logic             dv_signed;
    logic [31:0]      dv_x;
    logic [31:0]      dv_y;
    logic             dv_cancel;
    logic [31:0]      dv_s = '0;
    logic [31:0]      dv_r = '0;
    logic             dv_complete = 1'b0;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_lo;
    logic [31:0]      resp_hi;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    div_issue_ctrl #(.TAG_W(TAG_W), .MAX_LAT(MAX_LAT)) dut (
        .div_clk    (div_clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_tag    (req_tag),
        .flush      (flush),
        .dv_div     (dv_div),
        .dv_signed  (dv_signed),
        .dv_x       (dv_x),
        .dv_y       (dv_y),
        .dv_cancel  (dv_cancel),
        .dv_s       (dv_s),
        .dv_r       (dv_r),
        .dv_complete(dv_complete),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lo    (resp_lo),
        .resp_hi    (resp_hi),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err)
    );

    always #5 div_clk = ~div_clk;

    int cyc = 0;
    always @(posedge div_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- expected-event scoreboards ----------------
    typedef struct {
        logic [31:0]      lo;
        logic [31:0]      hi;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               vcyc;  // first cycle resp_valid is high
        int               hcyc;  // handshake cycle, -1 = don't care / none
        int               kcyc;  // flush-kill cycle, -1 = none
    } resp_t;

    typedef struct {
        int          c;
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
    } div_t;

    resp_t resp_q[$];
    div_t  div_q[$];
    int    cancel_q[$];

    // ---------------- divider stub ----------------
    bit   stub_never = 1'b0;
    bit   stub_busy  = 1'b0;
    int   stub_cnt   = 0;

    always @(posedge div_clk) begin
        dv_complete <= 1'b0;
        if (dv_cancel) begin
            stub_busy <= 1'b0;
        end else if (dv_div) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 16;
            if (dv_y == 32'd0) begin
                dv_s <= 32'hFFFF_FFFF;
                dv_r <= dv_x;
            end else if (dv_signed) begin
                dv_s <= $signed(dv_x) / $signed(dv_y);
                dv_r <= $signed(dv_x) % $signed(dv_y);
            end else begin
                dv_s <= dv_x / dv_y;
                dv_r <= dv_x % dv_y;
            end
        end else if (stub_busy && !stub_never) begin
            if (stub_cnt == 1) begin
                dv_complete <= 1'b1;
                stub_busy   <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // ---------------- monitors ----------------
    bit front_seen = 1'b0;

    always @(negedge div_clk) begin
        if (resetn) begin
            if (dv_div) begin
                if (div_q.size() == 0) fail_now("unexpected dv_div");
                else begin
                    div_t d;
                    d = div_q.pop_front();
                    chk("dv_div cycle", cyc, d.c);
                    chk("dv_signed", {31'd0, dv_signed}, {31'd0, d.sgn});
                    chk("dv_x", dv_x, d.x);
                    chk("dv_y", dv_y, d.y);
                end
            end
            if (dv_cancel) begin
                if (cancel_q.size() == 0) fail_now("unexpected dv_cancel");
                else chk("dv_cancel cycle", cyc, cancel_q.pop_front());
            end
            if (resp_q.size() == 0) begin
                if (resp_valid) fail_now("unexpected resp_valid");
            end else begin
                resp_t e;
                e = resp_q[0];
                if (e.kcyc == cyc) begin
                    chk("resp_valid under flush", {31'd0, resp_valid}, 32'd0);
                    void'(resp_q.pop_front());
                    front_seen = 1'b0;
                end else if (resp_valid) begin
                    if (!front_seen) chk("resp_valid cycle", cyc, e.vcyc);
                    front_seen = 1'b1;
                    chk("resp_lo", resp_lo, e.lo);
                    chk("resp_hi", resp_hi, e.hi);
                    chk("resp_tag", {28'd0, resp_tag}, {28'd0, e.tag});
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    if (resp_ready) begin
                        if (e.hcyc >= 0) chk("handshake cycle", cyc, e.hcyc);
                        void'(resp_q.pop_front());
                        front_seen = 1'b0;
                    end
                end else if (front_seen) begin
                    fail_now("resp_valid dropped");
                    void'(resp_q.pop_front());
                    front_seen = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge div_clk);
            #1;
        end
    endtask

    task automatic do_req(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] tag, output int t0);
        int n;
        req_valid  = 1'b1;
        req_signed = sgn;
        req_x      = x;
        req_y      = y;
        req_tag    = tag;
        n          = 0;
        t0         = -1;
        while (t0 < 0 && n < 50) begin
            @(negedge div_clk);
            if (req_ready) t0 = cyc;
            n++;
        end
        if (t0 < 0) fail_now("accept timeout");
        @(posedge div_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic push_div(input int c, input logic sgn, input logic [31:0] x, input logic [31:0] y);
        div_t d;
        d.c = c; d.sgn = sgn; d.x = x; d.y = y;
        div_q.push_back(d);
    endtask

    task automatic push_resp(input logic [31:0] lo, input logic [31:0] hi, input logic [TAG_W-1:0] tag,
                             input logic err, input int vcyc, input int hcyc, input int kcyc);
        resp_t e;
        e.lo = lo; e.hi = hi; e.tag = tag; e.err = err;
        e.vcyc = vcyc; e.hcyc = hcyc; e.kcyc = kcyc;
        resp_q.push_back(e);
    endtask

    task automatic pulse_flush(input int n);
        wait_cyc(n);
        flush = 1'b1;
        @(posedge div_clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge div_clk);
            if (resp_q.size() == 0 && div_q.size() == 0 && cancel_q.size() == 0 && req_ready) break;
            n++;
        end
        if (n >= 100) begin
            fail_now("drain timeout");
            resp_q.delete();
            div_q.delete();
            cancel_q.delete();
        end
        @(posedge div_clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t0;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge div_clk);
        @(negedge div_clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset dv_div", {31'd0, dv_div}, 32'd0);
        chk("reset dv_cancel", {31'd0, dv_cancel}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset resp_lo", resp_lo, 32'd0);
        chk("reset dv_x", dv_x, 32'd0);
        @(posedge div_clk);
        #1;
        resetn = 1'b1;
        @(posedge div_clk);
        #1;

        // DIVU 7/2
        do_req(1'b0, 32'd7, 32'd2, 4'h5, t0);
        push_div(t0 + 1, 1'b0, 32'd7, 32'd2);
        push_resp(32'd3, 32'd1, 4'h5, 1'b0, t0 + 19, t0 + 19, -1);
        wait_cyc(t0 + 20);
        @(negedge div_clk);
        chk("req_ready after resp", {31'd0, req_ready}, 32'd1);
        drain();

        // DIV -7/2
        do_req(1'b1, 32'hFFFF_FFF9, 32'd2, 4'hA, t0);
        push_div(t0 + 1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        push_resp(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'hA, 1'b0, t0 + 19, t0 + 19, -1);
        drain();

        // flush while in WAIT, then a normal divide
        do_req(1'b0, 32'd100, 32'd7, 4'h3, t0);
        push_div(t0 + 1, 1'b0, 32'd100, 32'd7);
        cancel_q.push_back(t0 + 6);
        pulse_flush(t0 + 6);
        wait_cyc(t0 + 7);
        @(negedge div_clk);
        chk("req_ready after flush", {31'd0, req_ready}, 32'd1);
        repeat (20) @(posedge div_clk);
        #1;
        do_req(1'b0, 32'd100, 32'd7, 4'h4, t0);
        push_div(t0 + 1, 1'b0, 32'd100, 32'd7);
        push_resp(32'd14, 32'd2, 4'h4, 1'b0, t0 + 19, t0 + 19, -1);
        drain();

        // response backpressure for 10 cycles
        resp_ready = 1'b0;
        do_req(1'b0, 32'hFFFF_FFFF, 32'd16, 4'h6, t0);
        push_div(t0 + 1, 1'b0, 32'hFFFF_FFFF, 32'd16);
        push_resp(32'h0FFF_FFFF, 32'd15, 4'h6, 1'b0, t0 + 19, t0 + 29, -1);
        wait_cyc(t0 + 29);
        resp_ready = 1'b1;
        drain();

        // flush in DONE discards the result
        resp_ready = 1'b0;
        do_req(1'b1, 32'd20, 32'hFFFF_FFFD, 4'h7, t0);
        push_div(t0 + 1, 1'b1, 32'd20, 32'hFFFF_FFFD);
        push_resp(32'hFFFF_FFFA, 32'd2, 4'h7, 1'b0, t0 + 19, -1, t0 + 21);
        wait_cyc(t0 + 21);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(posedge div_clk);
        #1;
        flush = 1'b0;
        drain();

        // watchdog: divider never completes
        stub_never = 1'b1;
        do_req(1'b0, 32'd55, 32'd5, 4'h8, t0);
        push_div(t0 + 1, 1'b0, 32'd55, 32'd5);
        cancel_q.push_back(t0 + 33);
        push_resp(32'd0, 32'd0, 4'h8, 1'b1, t0 + 34, t0 + 34, -1);
        drain();
        stub_never = 1'b0;

        // zero divisor
        do_req(1'b0, 32'h0000_1234, 32'd0, 4'h9, t0);
`ifdef DIV_ZERO_BYPASS_EN
        push_resp(32'hFFFF_FFFF, 32'h0000_1234, 4'h9, 1'b0, t0 + 2, t0 + 2, -1);
`else
        push_div(t0 + 1, 1'b0, 32'h0000_1234, 32'd0);
        push_resp(32'hFFFF_FFFF, 32'h0000_1234, 4'h9, 1'b0, t0 + 19, t0 + 19, -1);
`endif
        drain();

        chk("responses outstanding", resp_q.size(), 32'd0);
        chk("dv_div outstanding", div_q.size(), 32'd0);
        chk("dv_cancel outstanding", cancel_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
